// File: rtl/led_breath_scheduler_if.sv
// rtl/led_breath_scheduler_if.sv - mode command handshake for the LED scheduler
interface led_breath_scheduler_if #(
  parameter int CH_W = 2
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [CH_W-1:0] cmd_chan;
  logic [1:0]      cmd_mode;

  modport master (output cmd_valid, output cmd_chan, output cmd_mode, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_chan, input cmd_mode, output cmd_ready);
endinterface

// File: rtl/led_breath_scheduler.sv
// rtl/led_breath_scheduler.sv - per-channel LED off/on/blink/breathe duty scheduler
// One shared sine-table lookup is time-multiplexed across channels on every phase tick.
module led_breath_scheduler #(
  parameter int CHANNELS    = 4,
  parameter int STEP_CYCLES = 97656,
  parameter int CH_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  led_breath_scheduler_if.slave cmd,
  output logic [7:0]            sin_index,
  input  logic [7:0]            sin_value,
  output logic [8*CHANNELS-1:0] duty,
  output logic                  busy
);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BREATHE = 2'd3;

  typedef enum logic [1:0] {IDLE, ADDR, CAPT} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   step_cnt;
  logic            tick, tick_pend, accept, start, last;
  logic [CH_W-1:0] ch;
  logic [1:0]      mode   [CHANNELS];
  logic [8:0]      phase  [CHANNELS];
  logic [7:0]      duty_r [CHANNELS];
  logic [8:0]      cur_phase;
  logic [1:0]      cur_mode;

  // Fold the 9-bit phase into a rising-then-falling 8-bit table address.
  function automatic logic [7:0] fold_phase(input logic [8:0] p);
    return p[8] ? 8'(9'd511 - p) : p[7:0];
  endfunction

  assign tick      = (step_cnt == SW'(STEP_CYCLES - 1));
  assign cur_phase = phase[ch];
  assign cur_mode  = mode[ch];
  assign last      = (ch == CH_W'(CHANNELS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cmd.cmd_ready = 1'b0;
    busy          = 1'b0;
    accept        = 1'b0;
    start         = 1'b0;
    case (state)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        accept        = cmd.cmd_valid;
        if (!cmd.cmd_valid && tick_pend) begin
          start     = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        busy      = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: begin
        busy      = 1'b1;
        state_nxt = last ? IDLE : ADDR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_cnt  <= '0;
      tick_pend <= 1'b0;
      ch        <= '0;
      sin_index <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i]   <= M_OFF;
        phase[i]  <= '0;
        duty_r[i] <= '0;
      end
    end else begin
      step_cnt <= tick ? '0 : step_cnt + SW'(1);
      // A tick landing on the scan-start cycle must win over the clear.
      if (tick)       tick_pend <= 1'b1;
      else if (start) tick_pend <= 1'b0;
      if (start) ch <= '0;

      if (accept) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (cmd.cmd_chan == CH_W'(i)) begin
            mode[i]  <= cmd.cmd_mode;
            phase[i] <= '0;
            if (cmd.cmd_mode == M_OFF) duty_r[i] <= 8'h00;
            if (cmd.cmd_mode == M_ON)  duty_r[i] <= 8'hFF;
          end
        end
      end

      if (state == ADDR) sin_index <= fold_phase(cur_phase);

      if (state == CAPT) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (ch == CH_W'(i)) begin
            case (cur_mode)
              M_BREATHE: duty_r[i] <= sin_value;
              M_BLINK:   duty_r[i] <= cur_phase[8] ? 8'h00 : 8'hFF;
              M_ON:      duty_r[i] <= 8'hFF;
              default:   duty_r[i] <= 8'h00;
            endcase
            if (cur_mode[1]) phase[i] <= cur_phase + 9'd1;
          end
        end
        if (!last) ch <= ch + CH_W'(1);
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_duty
    assign duty[8*g +: 8] = duty_r[g];
  end
endmodule

// File: tb/tb_led_breath_scheduler.sv
// tb/tb_led_breath_scheduler.sv - self-checking bench for led_breath_scheduler
module tb_led_breath_scheduler;
  localparam int CHANNELS = 3;
  localparam int STEP     = 20;
  localparam int CH_W     = 2;

  logic                  clk;
  logic                  rst;
  logic [7:0]            sin_index;
  logic [7:0]            sin_value;
  logic [8*CHANNELS-1:0] duty;
  logic                  busy;
  int                    tb_cnt;
  int                    passed;
  int                    total;
  int                    exp_idx[$];
  int                    exp_d0[$];
  int                    exp_d1[$];

  led_breath_scheduler_if #(.CH_W(CH_W)) cmd_if ();

  led_breath_scheduler #(
    .CHANNELS(CHANNELS), .STEP_CYCLES(STEP), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .sin_index(sin_index),
    .sin_value(sin_value), .duty(duty), .busy(busy)
  );

  function automatic logic [7:0] tbl(input logic [7:0] i);
    logic [7:0] m;
    m = i * 8'd37;
    return m ^ 8'h5C;
  endfunction

  function automatic int fold(input int p);
    return (p < 256) ? p : 511 - p;
  endfunction

  assign sin_value = tbl(sin_index);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference step counter: the tick cycle is where tb_cnt == STEP-1.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_cnt <= 0;
    else      tb_cnt <= (tb_cnt == STEP - 1) ? 0 : tb_cnt + 1;
  end

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    @(negedge clk);
    while (tb_cnt != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (tb_cnt != v) begin
      total++;
      $display("FAIL wait_cnt: tb_cnt=%0d required %0d", tb_cnt, v);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [1:0] m);
    wait_cnt(10);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_chan  = c;
    cmd_if.cmd_mode  = m;
    total++;
    if (cmd_if.cmd_ready !== 1'b1) $display("FAIL send_ready: got %b required 1", cmd_if.cmd_ready);
    else passed++;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if (duty !== '0) $display("FAIL reset_duty: got %h required 0", duty); else passed++;
    total++;
    if (cmd_if.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", cmd_if.cmd_ready); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
    total++;
    if (sin_index !== 8'd0) $display("FAIL reset_index: got %0d required 0", sin_index); else passed++;
  endtask

  task automatic test_breathe_blink;
    int p;
    send(2'd1, 2'd2);
    total++;
    if (duty[15:8] !== 8'd0) $display("FAIL blink_keep_old: got %0d required 0", duty[15:8]); else passed++;
    send(2'd0, 2'd3);
    for (int k = 0; k <= 512; k++) begin
      wait_cnt(STEP - 1);
      p = fold(k % 512);
      exp_idx.push_back(p);
      exp_d0.push_back(int'(tbl(8'(p))));
      exp_d1.push_back((((k + 1) % 512) < 256) ? 255 : 0);
      repeat (3) @(posedge clk);
      #1;
      p = exp_idx.pop_front();
      total++;
      if (sin_index !== 8'(p)) $display("FAIL breathe_index k=%0d: got %0d required %0d", k, sin_index, p); else passed++;
      @(posedge clk);
      #1;
      p = exp_d0.pop_front();
      total++;
      if (duty[7:0] !== 8'(p)) $display("FAIL breathe_duty k=%0d: got %0d required %0d", k, duty[7:0], p); else passed++;
      repeat (2) @(posedge clk);
      #1;
      p = exp_d1.pop_front();
      total++;
      if (duty[15:8] !== 8'(p)) $display("FAIL blink_duty k=%0d: got %0d required %0d", k, duty[15:8], p); else passed++;
    end
  endtask

  task automatic test_out_of_range;
    send(2'd3, 2'd1);
    total++;
    if (duty !== {8'd0, 8'd255, tbl(8'd0)}) $display("FAIL oor_accept: got %h required %h", duty, {8'd0, 8'd255, tbl(8'd0)}); else passed++;
    wait_cnt(STEP - 1);
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (duty !== {8'd0, 8'd255, tbl(8'd1)}) $display("FAIL oor_next_scan: got %h required %h", duty, {8'd0, 8'd255, tbl(8'd1)}); else passed++;
  endtask

  task automatic test_restart;
    repeat (298) wait_cnt(STEP - 1);
    send(2'd0, 2'd3);
    total++;
    if (duty[7:0] !== tbl(8'd212)) $display("FAIL restart_keep: got %0d required %0d", duty[7:0], tbl(8'd212)); else passed++;
    wait_cnt(STEP - 1);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (duty[7:0] !== tbl(8'd0)) $display("FAIL restart_duty: got %0d required %0d", duty[7:0], tbl(8'd0)); else passed++;
  endtask

  task automatic test_on_off;
    send(2'd2, 2'd1);
    total++;
    if (duty[23:16] !== 8'd255) $display("FAIL on_latency: got %0d required 255", duty[23:16]); else passed++;
    send(2'd2, 2'd0);
    total++;
    if (duty[23:16] !== 8'd0) $display("FAIL off_latency: got %0d required 0", duty[23:16]); else passed++;
  endtask

  task automatic test_cmd_hold;
    int n;
    wait_cnt(STEP - 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_chan  = 2'd2;
    cmd_if.cmd_mode  = 2'd1;
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 2 * CHANNELS) $display("FAIL hold_ready_low: got %0d cycles required %0d", n, 2 * CHANNELS); else passed++;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    total++;
    if (duty[23:16] !== 8'd255) $display("FAIL hold_accept: got %0d required 255", duty[23:16]); else passed++;
  endtask

  task automatic test_tick_priority;
    wait_cnt(STEP - 1);
    @(negedge clk);
    total++;
    if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL prio_idle: got ready=%b busy=%b required ready=1 busy=0", cmd_if.cmd_ready, busy); else passed++;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_chan  = 2'd2;
    cmd_if.cmd_mode  = 2'd0;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || duty[23:16] !== 8'd0) $display("FAIL prio_cmd_first: got busy=%b duty2=%0d required busy=0 duty2=0", busy, duty[23:16]); else passed++;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) $display("FAIL prio_scan_delayed: got busy=%b required 1", busy); else passed++;
  endtask

  task automatic test_midscan_reset;
    wait_cnt(STEP - 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL midscan_busy: got %b required 1", busy); else passed++;
    rst = 1'b0;
    #1;
    test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b0 || duty !== '0) $display("FAIL midscan_dropped: got busy=%b duty=%h required busy=0 duty=0", busy, duty); else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    passed           = 0;
    total            = 0;
    rst              = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_chan  = '0;
    cmd_if.cmd_mode  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset;
    test_breathe_blink;
    test_out_of_range;
    test_restart;
    test_on_off;
    test_cmd_hold;
    test_tick_priority;
    test_midscan_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/led_breath_scheduler.md
Name: led_breath_scheduler

Overview:
- Per-channel LED effect controller for several PWM-driven LEDs; runs from the 50 MHz clock.
- Keeps a mode and a phase for each channel.
- Shares one combinational sin_table lookup between all channels by scanning them in turn once per phase tick.
- Writes an 8-bit duty per channel; each duty feeds that channel's pwm instance (period 256).

Parameters:
- CHANNELS, 4, number of LED channels (2..8).
- STEP_CYCLES, 97656, clock cycles per phase tick. Default gives a 512-tick breathe cycle of about 1 s at 50 MHz. Must be ≥ 2*CHANNELS+2.
- CH_W, 2, width of the channel select, = clog2(CHANNELS).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  a mode command is offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising clk edge.
- cmd_chan  in  CH_W  target channel. Values ≥ CHANNELS are accepted and ignored.
- cmd_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BREATHE.
- sin_index  out  8  registered address to the shared sin_table.
- sin_value  in  8  combinational table result for sin_index.
- duty  out  8*CHANNELS  channel i duty on bits [8i+7:8i], registered.
- busy  out  1  high while a scan is in progress.

Behaviour:
- Reset (rst=0, async) clears:
  - all duty to 0, all modes to OFF, all 9-bit phases to 0;
  - sin_index, step_cnt, tick_pend and busy to 0;
  - state to IDLE.
  cmd_ready=1 after reset, since cmd_ready is combinational from (state==IDLE).
- Tick generation: step_cnt counts 0..STEP_CYCLES-1 and wraps. The tick fires in the cycle where step_cnt==STEP_CYCLES-1 and sets tick_pend. step_cnt runs in every state.
- State machine IDLE / ADDR / CAPT, with channel pointer ch:
  - IDLE, command accepted: applies the command this cycle and stays in IDLE. If a tick is pending, the scan starts on the next cycle, so a command takes priority over a tick in the same cycle.
  - IDLE, tick_pend=1 and no command accepted: ch←0, tick_pend←0, go to ADDR.
  - ADDR: sin_index ← tri(phase[ch]), go to CAPT.
    - tri(p) = p[8] ? 511-p : p[7:0].
    - So the index runs 0..255, then 255..0; 255 and 0 each repeat once at the turn.
  - CAPT: update duty[ch] by mode:
    - BREATHE: duty ← sin_value.
    - BLINK: duty ← phase[8] ? 0 : 255.
    - ON: duty ← 255.
    - OFF: duty ← 0.
  - CAPT, phase: for BREATHE and BLINK, phase[ch] ← phase[ch]+1 mod 512, applied after use. For OFF and ON, phase holds.
  - CAPT, exit: if ch==CHANNELS-1, go to IDLE; else ch+1 and go to ADDR.
- Scan length: 2*CHANNELS cycles. busy=1 in ADDR and CAPT.
- A tick arriving during a scan sets tick_pend. It is serviced on return to IDLE. Ticks never queue beyond one.
- Command application (in IDLE only):
  - mode[cmd_chan] ← cmd_mode;
  - phase[cmd_chan] ← 0;
  - duty updates immediately for OFF (0) and ON (255);
  - BLINK and BREATHE keep the old duty until the next scan;
  - re-issuing the same mode also restarts the phase.
- Latency:
  - command to duty for OFF/ON: 1 cycle;
  - tick to channel i duty update, when IDLE at the tick: 2i+3 cycles.
- Wrap: phase 511 → 0, with no glitch in duty sequence continuity.
- Reset mid-scan returns to IDLE at once. Any pending tick and partial updates are dropped.

Test Plan:
- Reset, then release → duty=0 for all channels, cmd_ready=1, busy=0, sin_index=0. Asserting rst=0 mid-scan forces the same values immediately.
- STEP_CYCLES=20, ch0 BREATHE, sin_table model → sin_index sequence over 512 ticks is 0,1,…,255,255,254,…,0. duty0 equals the table value for each index, 3 cycles after each tick.
- ch1 BLINK → duty1=255 for 256 ticks, then 0 for 256 ticks, repeating. ch2 ON → duty2=255 one cycle after acceptance. Then OFF → 0 one cycle later.
- cmd_valid held through a scan → cmd_ready=0 for exactly 2*CHANNELS cycles. The command is accepted on the first IDLE cycle. A command in the tick cycle delays the scan by 1 cycle; no tick is lost.
- cmd_chan=3 with CHANNELS=3 → accepted, no duty, mode or phase changes. BREATHE restart on ch0 at phase 300 → next duty0 = table(0).
